// File: rtl/boot_rom_patch_pkg.sv
// Shared definitions for the boot ROM with patch region: default boot image,
// FSM states and an image lookup helper.
package boot_pkg;

  localparam int unsigned BOOT_IMG_LEN = 8;
  localparam int unsigned IMG_IW       = 3;

  localparam logic [15:0] BOOT_IMG [BOOT_IMG_LEN] = '{
    16'hF200, 16'h4000, 16'hF800, 16'h1007,
    16'hF400, 16'h3008, 16'h4000, 16'h0000
  };

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } boot_state_e;

  // Words beyond the built-in image read as zero when ROM_WORDS exceeds it.
  function automatic logic [15:0] boot_img_word(input int unsigned idx);
    logic [IMG_IW-1:0] i;
    i = idx[IMG_IW-1:0];
    return (idx < BOOT_IMG_LEN) ? BOOT_IMG[i] : 16'h0000;
  endfunction

endpackage

// File: rtl/boot_rom_patch_if.sv
// Request/response bus of the boot ROM: the fetch master issues reads and
// patch writes; the ROM returns registered data and status strobes.
interface boot_rom_patch_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          lock;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          ready;
  logic          wr_err;
  logic          locked;

  modport master (
    output cs, we, addr, din, lock,
    input  dout, rvalid, ready, wr_err, locked
  );

  modport slave (
    input  cs, we, addr, din, lock,
    output dout, rvalid, ready, wr_err, locked
  );
endinterface

// File: rtl/boot_patch_bank.sv
// Patch register file: one write port shared by the post-reset clear and
// user writes, combinational read. Storage itself is never reset.
module boot_patch_bank #(
  parameter int DW    = 16,
  parameter int WORDS = 4,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/boot_rom_patch.sv
// Boot ROM with hardwired image in the low words and a lockable patch region
// above it that is cleared by hardware after every reset.
module boot_rom_patch
  import boot_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 4,
  parameter int DEPTH     = 12,
  parameter int ROM_WORDS = 8
) (
  input logic             clk,
  input logic             rst_n,
  boot_rom_patch_if.slave bus
);

  localparam int PATCH_WORDS = DEPTH - ROM_WORDS;
  // A zero-size patch region still gets one dummy word so the bank elaborates.
  localparam int BANK_WORDS  = (PATCH_WORDS > 0) ? PATCH_WORDS : 1;
  localparam int IW          = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

  localparam logic [AW:0] ROM_LIM   = (AW+1)'(ROM_WORDS);
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  boot_state_e   state, state_nxt;
  logic [IW-1:0] cnt;
  logic          init_last;

  logic [AW:0]   addr_x;
  logic          in_rom, in_patch;
  logic          accept, rd, wr, wr_ok;
  logic [IW-1:0] patch_idx;

  logic          bank_wen;
  logic [IW-1:0] bank_waddr;
  logic [DW-1:0] bank_wdata, bank_rdata;
  logic [DW-1:0] rd_word;

  assign bus.ready  = (state != INIT);
  assign bus.locked = (state == LOCKED);

  assign addr_x    = {1'b0, bus.addr};
  assign in_rom    = (addr_x < ROM_LIM);
  assign in_patch  = !in_rom && (addr_x < DEPTH_LIM);
  assign patch_idx = IW'(addr_x - ROM_LIM);

  assign accept = bus.cs & bus.ready;
  assign rd     = accept & ~bus.we;
  assign wr     = accept & bus.we;
  assign wr_ok  = wr & (state == OPEN) & in_patch;

  assign init_last = (cnt == IW'(BANK_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_last) state_nxt = OPEN;
      OPEN:    if (bus.lock)  state_nxt = LOCKED;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = INIT;
    endcase
  end

  // Clearing during INIT and user writes share the bank's single port.
  always_comb begin
    bank_wen   = 1'b0;
    bank_waddr = patch_idx;
    bank_wdata = bus.din;
    if (state == INIT) begin
      bank_wen   = 1'b1;
      bank_waddr = cnt;
      bank_wdata = '0;
    end else if (wr_ok) begin
      bank_wen   = 1'b1;
    end
  end

  boot_patch_bank #(
    .DW    (DW),
    .WORDS (BANK_WORDS),
    .IW    (IW)
  ) u_bank (
    .clk   (clk),
    .wen   (bank_wen),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (patch_idx),
    .rdata (bank_rdata)
  );

  always_comb begin
    rd_word = '0;
    if (in_rom)        rd_word = DW'(boot_img_word(int'(bus.addr)));
    else if (in_patch) rd_word = bank_rdata;
  end

  // Read data and status strobes are registered one cycle after the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout   <= '0;
      bus.rvalid <= 1'b0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.rvalid <= rd;
      bus.wr_err <= wr & ~wr_ok;
      if (rd) bus.dout <= rd_word;
    end
  end

endmodule

// File: tb/tb_boot_rom_patch.sv
// Directed bench for boot_rom_patch: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_boot_rom_patch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst0_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  boot_rom_patch_if #(.DW(16), .AW(4)) bus ();
  boot_rom_patch_if #(.DW(16), .AW(4)) bus0 ();

  boot_rom_patch #(.DW(16), .AW(4), .DEPTH(12), .ROM_WORDS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  boot_rom_patch #(.DW(16), .AW(4), .DEPTH(8), .ROM_WORDS(8)) dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus0)
  );

  typedef struct {
    bit          kind;   // 0 = read data, 1 = wr_err pulse
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && (bus.rvalid || bus.wr_err)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp rvalid=%0b wr_err=%0b dout=%h cyc=%0d",
                 bus.rvalid, bus.wr_err, bus.dout, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((bus.rvalid && bus.wr_err) ||
            (e.kind == 1'b0 && (!bus.rvalid || bus.dout !== e.data)) ||
            (e.kind == 1'b1 && !bus.wr_err) ||
            (cyc != e.cyc)) begin
          bad++;
          $display("FAIL resp kind=%0b got rvalid=%0b wr_err=%0b dout=%h cyc=%0d exp dout=%h cyc=%0d",
                   e.kind, bus.rvalid, bus.wr_err, bus.dout, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.cs = 1'b0; bus.we = 1'b0; bus.lock = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; the request is accepted at the next edge.
  task automatic issue(input bit w, input logic [3:0] a, input logic [15:0] d,
                       input bit lk, input bit resp, input logic [15:0] exp);
    exp_t e;
    bus.cs = 1'b1; bus.we = w; bus.addr = a; bus.din = d; bus.lock = lk;
    if (resp) begin
      e.kind = w; e.data = exp; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.lock = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp);
    issue(1'b0, a, 16'h0, 1'b0, 1'b1, exp);
  endtask

  // Counts edges until ready; drops cs as soon as ready is seen.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_dout"},   32'(bus.dout),   32'h0);
    check({nm, "_rvalid"}, 32'(bus.rvalid), 32'h0);
    check({nm, "_ready"},  32'(bus.ready),  32'h0);
    check({nm, "_wr_err"}, 32'(bus.wr_err), 32'h0);
    check({nm, "_locked"}, 32'(bus.locked), 32'h0);
  endtask

  logic [15:0] img [8] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007,
                           16'hF400, 16'h3008, 16'h4000, 16'h0000};

  initial begin
    int n;
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.din = 0; bus.lock = 0;
    bus0.cs = 0; bus0.we = 0; bus0.addr = 0; bus0.din = 0; bus0.lock = 0;

    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(n);
    check("ready_cycles", 32'(n), 32'd4);

    for (int a = 8; a < 12; a++) rd(4'(a), 16'h0000);
    for (int a = 0; a < 8; a++) rd(4'(a), img[a]);

    issue(1'b1, 4'd9, 16'hA5A5, 1'b0, 1'b0, 16'h0);
    rd(4'd9, 16'hA5A5);
    issue(1'b1, 4'd3, 16'h1234, 1'b0, 1'b1, 16'h0);
    rd(4'd3, 16'h1007);
    issue(1'b1, 4'd15, 16'h5555, 1'b0, 1'b1, 16'h0);
    rd(4'd15, 16'h0000);

    issue(1'b1, 4'd10, 16'hBEEF, 1'b1, 1'b0, 16'h0);
    check("locked_after_lock", 32'(bus.locked), 32'h1);
    rd(4'd10, 16'hBEEF);
    issue(1'b1, 4'd10, 16'h0000, 1'b0, 1'b1, 16'h0);
    rd(4'd10, 16'hBEEF);
    issue(1'b1, 4'd14, 16'h7777, 1'b0, 1'b1, 16'h0);
    rd(4'd14, 16'h0000);
    rd(4'd9, 16'hA5A5);
    idle(2);

    // Mid-INIT reset with cs held high through the clear sequence.
    rst_n = 1'b0; #1;
    check_reset_outputs("rst2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 4'd2;
    idle(0);
    bus.cs = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_midinit");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 4'd9; bus.din = 16'hDEAD;
    wait_ready(n);
    check("ready_cycles_midinit", 32'(n), 32'd4);
    rd(4'd9, 16'h0000);

    issue(1'b1, 4'd8, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    rd(4'd8, 16'hFFFF);
    issue(1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 16'hF200);
    check("locked_second", 32'(bus.locked), 32'h1);
    idle(2);

    rst_n = 1'b0; #1;
    check_reset_outputs("rst_midstream");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(n);
    check("ready_cycles_3", 32'(n), 32'd4);
    rd(4'd8, 16'h0000);
    idle(3);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    // Zero-size patch region: ready after one cycle, every write rejected.
    rst0_n = 1'b1;
    n = 0;
    while (!bus0.ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("p0_ready_cycles", 32'(n), 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus0.cs = 1'b1; bus0.we = 1'b1; bus0.din = 16'h1111;
      bus0.addr = (k == 0) ? 4'd8 : (k == 1) ? 4'd3 : 4'd15;
      @(posedge clk); #1;
      bus0.cs = 1'b0; bus0.we = 1'b0;
      check("p0_wr_err", 32'(bus0.wr_err), 32'h1);
    end
    bus0.cs = 1'b1; bus0.we = 1'b0; bus0.addr = 4'd2;
    @(posedge clk); #1;
    bus0.cs = 1'b0;
    check("p0_rvalid", 32'(bus0.rvalid), 32'h1);
    check("p0_rd2", 32'(bus0.dout), 32'hF800);
    check("p0_no_err", 32'(bus0.wr_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
